// File: rtl/sop_tree_sequencer.sv
// Time-multiplexed OR-of-ANDs evaluator: a shared LANES-wide AND-OR slice steps
// across the captured operands one chunk per cycle, with an optional early exit.
module sop_tree_sequencer #(
   parameter int PAIRS      = 8,
   parameter int LANES      = 2,
   parameter int EARLY_EXIT = 1,
   parameter int CW         = $clog2(PAIRS / LANES) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PAIRS-1:0] in_a,
   input  logic [PAIRS-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_y,
   output logic [CW-1:0]    out_cycles,
   output logic             busy
);

   localparam int NCHUNK = PAIRS / LANES;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t           r_state;
   state_t           w_stateNext;

   logic [PAIRS-1:0] r_a;
   logic [PAIRS-1:0] r_b;
   logic             r_acc;
   logic [IW-1:0]    r_idx;
   logic [CW-1:0]    r_cnt;
   logic             r_outY;
   logic [CW-1:0]    r_outCycles;

   logic [LANES-1:0] w_chunkA;
   logic [LANES-1:0] w_chunkB;
   logic             w_chunk;
   logic             w_accNext;
   logic [CW-1:0]    w_cntNext;
   logic             w_lastChunk;
   logic             w_finish;

   // Shared slice: only the chunk selected by r_idx is evaluated this cycle.
   assign w_chunkA    = r_a[int'(r_idx) * LANES +: LANES];
   assign w_chunkB    = r_b[int'(r_idx) * LANES +: LANES];
   assign w_chunk     = |(w_chunkA & w_chunkB);
   assign w_accNext   = r_acc | w_chunk;
   assign w_cntNext   = r_cnt + CW'(1);
   assign w_lastChunk = (r_idx == IW'(NCHUNK - 1));
   assign w_finish    = w_lastChunk || ((EARLY_EXIT != 0) && w_accNext);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_stateNext = EVAL;
         EVAL:    if (w_finish)  w_stateNext = DONE;
         DONE:    if (out_ready) w_stateNext = IDLE;
         default:                w_stateNext = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      busy      = (r_state == EVAL) || (r_state == DONE);
      out_valid = (r_state == DONE);
   end

   // Result registers are written only on the final EVAL step, so they stay
   // frozen throughout DONE regardless of backpressure or new operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_outY      <= 1'b0;
         r_outCycles <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= in_a;
                  r_b   <= in_b;
                  r_acc <= 1'b0;
                  r_idx <= '0;
                  r_cnt <= '0;
               end
            end
            EVAL: begin
               if (w_finish) begin
                  r_outY      <= w_accNext;
                  r_outCycles <= w_cntNext;
               end else begin
                  r_acc <= w_accNext;
                  r_cnt <= w_cntNext;
                  r_idx <= r_idx + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_y      = r_outY;
   assign out_cycles = r_outCycles;

endmodule

// File: tb/tb_sop_tree_sequencer.sv
// Scoreboard bench for sop_tree_sequencer: three configurations run side by side,
// each with directed cases, a mid-evaluation reset and a random regression.
module tb_sop_tree_sequencer;

   typedef struct {
      bit y;
      int cycles;
      int capEdge;
   } expItem;

   logic clk;
   int   edgeCnt = 0;
   int   checks  = 0;
   int   fails   = 0;
   bit   done [3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s", name);
   endtask

   // cfg0: PAIRS=8 LANES=2 early exit; cfg1: same without early exit; cfg2: PAIRS=12 LANES=3.
   for (genvar g = 0; g < 3; g++) begin : gCfg
      localparam int P   = (g == 2) ? 12 : 8;
      localparam int L   = (g == 2) ? 3 : 2;
      localparam int E   = (g == 1) ? 0 : 1;
      localparam int NCH = P / L;
      localparam int CW  = $clog2(NCH) + 1;

      logic          rst;
      logic          inValid;
      logic          inReady;
      logic [P-1:0]  inA;
      logic [P-1:0]  inB;
      logic          outValid;
      logic          outReady;
      logic          outY;
      logic [CW-1:0] outCycles;
      logic          busy;

      int     readyMode     = 1;
      int     lastHsEdge    = -10;
      int     capEdge       = 0;
      bit     pushOnCapture = 1'b1;
      bit     mPrevValid    = 1'b0;
      bit     mPrevStall    = 1'b0;
      bit     mPrevY        = 1'b0;
      int     mPrevCyc      = 0;
      expItem scoreQ[$];

      sop_tree_sequencer #(
         .PAIRS(P),
         .LANES(L),
         .EARLY_EXIT(E)
      ) dut (
         .clk(clk),
         .rst(rst),
         .in_valid(inValid),
         .in_ready(inReady),
         .in_a(inA),
         .in_b(inB),
         .out_valid(outValid),
         .out_ready(outReady),
         .out_y(outY),
         .out_cycles(outCycles),
         .busy(busy)
      );

      // Reference: result is the OR of all products; the cycle count is the
      // chunk holding the lowest-numbered true product, or a full scan.
      function automatic expItem model(input logic [P-1:0] a, input logic [P-1:0] b);
         expItem       r;
         logic [P-1:0] t;
         t         = a & b;
         r.y       = |t;
         r.cycles  = NCH;
         r.capEdge = 0;
         if (E != 0) begin
            for (int i = P - 1; i >= 0; i--) begin
               if (t[i]) r.cycles = i / L + 1;
            end
         end
         return r;
      endfunction

      task automatic driveInputs(input logic [P-1:0] a, input logic [P-1:0] b);
         @(negedge clk);
         inA     = a;
         inB     = b;
         inValid = 1'b1;
      endtask

      task automatic waitCapture();
         expItem e;
         int     guard = 0;
         while (inReady !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
               reportFail($sformatf("cfg%0d capture timeout", g));
               return;
            end
         end
         e = model(inA, inB);
         @(posedge clk);
         #1;
         capEdge   = edgeCnt;
         e.capEdge = capEdge;
         if (pushOnCapture) scoreQ.push_back(e);
      endtask

      task automatic applyStimulus(input logic [P-1:0] a, input logic [P-1:0] b);
         driveInputs(a, b);
         waitCapture();
      endtask

      task automatic idleInputs();
         @(negedge clk);
         inValid = 1'b0;
      endtask

      task automatic waitIdle(input int limit);
         int guard = 0;
         while (!(inReady === 1'b1 && scoreQ.size() == 0)) begin
            @(negedge clk);
            guard++;
            if (guard > limit) begin
               reportFail($sformatf("cfg%0d drain timeout", g));
               return;
            end
         end
      endtask

      initial begin
         outReady = 1'b0;
         forever begin
            @(posedge clk);
            #2;
            case (readyMode)
               0:       outReady = ($urandom_range(0, 3) != 0);
               1:       outReady = 1'b1;
               default: outReady = 1'b0;
            endcase
         end
      end

      // Monitor: pops the scoreboard on each new result and watches handshake rules.
      initial begin
         expItem e;
         forever begin
            @(negedge clk);
            if (rst) begin
               mPrevValid = 1'b0;
               mPrevStall = 1'b0;
               continue;
            end
            if (busy) checkOutput($sformatf("cfg%0d in_ready while busy", g), inReady, 0);
            if (mPrevStall) begin
               checkOutput($sformatf("cfg%0d out_valid held", g), outValid, 1);
               checkOutput($sformatf("cfg%0d out_y held", g), outY, mPrevY);
               checkOutput($sformatf("cfg%0d out_cycles held", g), outCycles, mPrevCyc);
            end
            if (outValid && !mPrevValid) begin
               if (scoreQ.size() == 0) begin
                  reportFail($sformatf("cfg%0d unexpected out_valid y=%0d cycles=%0d", g, outY, outCycles));
               end else begin
                  e = scoreQ.pop_front();
                  checkOutput($sformatf("cfg%0d out_y", g), outY, e.y);
                  checkOutput($sformatf("cfg%0d out_cycles", g), outCycles, e.cycles);
                  checkOutput($sformatf("cfg%0d latency", g), edgeCnt - e.capEdge, e.cycles);
               end
            end
            mPrevValid = outValid;
            mPrevStall = outValid && !outReady;
            mPrevY     = outY;
            mPrevCyc   = outCycles;
            if (outValid && outReady) lastHsEdge = edgeCnt + 1;
         end
      end

      initial begin
         int guard;
         rst     = 1'b1;
         inValid = 1'b0;
         inA     = '0;
         inB     = '0;
         repeat (3) @(negedge clk);
         checkOutput($sformatf("cfg%0d reset in_ready", g), inReady, 1);
         checkOutput($sformatf("cfg%0d reset out_valid", g), outValid, 0);
         checkOutput($sformatf("cfg%0d reset out_y", g), outY, 0);
         checkOutput($sformatf("cfg%0d reset out_cycles", g), outCycles, 0);
         checkOutput($sformatf("cfg%0d reset busy", g), busy, 0);
         rst = 1'b0;

         applyStimulus(P'(8'hFF), P'(8'h00));
         idleInputs();
         applyStimulus(P'(8'h40), P'(8'h40));
         idleInputs();
         applyStimulus(P'(8'h01), P'(8'h01));
         idleInputs();

         // Backpressure: result stalls while the next operand waits on in_valid.
         waitIdle(50);
         readyMode = 2;
         applyStimulus(P'(8'h80), P'(8'h80));
         @(negedge clk);
         inA     = P'(8'h0C);
         inB     = P'(8'h04);
         inValid = 1'b1;
         guard   = 0;
         while (outValid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) reportFail($sformatf("cfg%0d out_valid timeout", g));
         repeat (5) @(negedge clk);
         readyMode = 1;
         waitCapture();
         checkOutput($sformatf("cfg%0d capture after handshake", g), capEdge, lastHsEdge + 1);
         idleInputs();

         // Reset during the second EVAL cycle discards the transaction.
         waitIdle(50);
         pushOnCapture = 1'b0;
         applyStimulus(P'(8'hFF), P'(8'h00));
         @(posedge clk);
         #2;
         rst     = 1'b1;
         inValid = 1'b0;
         #1;
         checkOutput($sformatf("cfg%0d async reset in_ready", g), inReady, 1);
         checkOutput($sformatf("cfg%0d async reset out_valid", g), outValid, 0);
         checkOutput($sformatf("cfg%0d async reset out_y", g), outY, 0);
         checkOutput($sformatf("cfg%0d async reset out_cycles", g), outCycles, 0);
         checkOutput($sformatf("cfg%0d async reset busy", g), busy, 0);
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("cfg%0d post reset in_ready", g), inReady, 1);
         checkOutput($sformatf("cfg%0d post reset out_valid", g), outValid, 0);
         pushOnCapture = 1'b1;

         // Random regression with random backpressure and post-capture operand churn.
         readyMode = 0;
         for (int n = 0; n < 1000; n++) begin
            applyStimulus(P'($urandom), P'($urandom & $urandom & $urandom));
            @(negedge clk);
            inA     = P'($urandom);
            inB     = P'($urandom);
            inValid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         readyMode = 1;
         waitIdle(200);
         done[g] = 1'b1;
      end
   end

   initial begin
      wait (done[0] && done[1] && done[2]);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL global timeout: checks=%0d failures=%0d", checks, fails);
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
